spi_slave_fifo: RTL and testbench

Parametrised SPI slave: next generation of the existing 8-bit `slave2`, with configurable word width and bit order, back-to-back multi-word frames while `cs` is held low, a one-entry TX holding register with valid/ready handshake, and an RX FIFO with valid/ready read port. Clocked directly by the SPI clock, SPI mode 0: sample on rising edge, MISO changes after rising edge. Sits between the SPI pins and the local register/datapath logic, which runs on `sclk`.

---
 rtl/spi_slave_fifo_if.sv | 40 ++++
 rtl/spi_slave_fifo.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fifo_if.sv
// SPI pin and local-side handshake bundle for spi_slave_fifo; err/err_clr exist only with SPI_SLV_ERR_EN.
// master = SPI host / local logic driving the slave, slave = spi_slave_fifo itself.
interface spi_slave_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          cs;
  logic                          mosi;
  logic                          miso;
  logic [DATA_W-1:0]             tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [DATA_W-1:0]             dout;
  logic                          rx_valid;
  logic                          rx_ready;
  logic [$clog2(FIFO_DEPTH):0]   rx_level;
  logic                          busy;
`ifdef SPI_SLV_ERR_EN
  logic [1:0]                    err;
  logic                          err_clr;

  modport master (
    output cs, mosi, tx_data, tx_valid, rx_ready, err_clr,
    input  miso, tx_ready, dout, rx_valid, rx_level, busy, err
  );
  modport slave (
    input  cs, mosi, tx_data, tx_valid, rx_ready, err_clr,
    output miso, tx_ready, dout, rx_valid, rx_level, busy, err
  );
`else
  modport master (
    output cs, mosi, tx_data, tx_valid, rx_ready,
    input  miso, tx_ready, dout, rx_valid, rx_level, busy
  );
  modport slave (
    input  cs, mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, dout, rx_valid, rx_level, busy
  );
`endif
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI mode-0 slave clocked by sclk, TX holding register + RX FIFO; SPI_SLV_ERR_EN adds sticky overrun/underrun flags.
// Latency: RX word visible right after its last sampled edge; TX word on miso one edge after IDLE accept (same edge on bypass).
// Backpressure: tx_ready low while holding register full; full RX FIFO drops new words unless popped on the same edge.
module spi_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             sclk,
  input  logic             i_reset,
  spi_slave_fifo_if.slave  bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e             st_q, st_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic               primed_q, primed_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;

  logic               sel;
  logic               last;
  logic               abort;
  logic               first_bit;
  logic               idle_load;
  logic               load;
  logic               tx_avail;
  logic               tx_acc;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic               overrun;
  logic               underrun;
  logic [DATA_W-1:0]  rx_shifted;
  logic [DATA_W-1:0]  tx_shifted;
  logic [DATA_W-1:0]  tx_next;

  assign sel       = ~bus.cs;
  assign last      = sel && (cnt_q == CNT_LAST);
  assign abort     = bus.cs && (cnt_q != '0);
  assign first_bit = sel && (cnt_q == '0);
  assign tx_avail  = hold_vld_q || bus.tx_valid;
  assign tx_next   = hold_vld_q ? hold_q : bus.tx_data;
  // Idle preload only while deselected: with cs low at counter 0 the word has
  // already started, so an unprimed word must stay all zeros.
  assign idle_load = bus.cs && (cnt_q == '0) && !primed_q && tx_avail;
  assign load      = idle_load || last;
  assign tx_acc    = bus.tx_valid && !hold_vld_q;

  assign rx_shifted = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], bus.mosi}
                                : {bus.mosi, rx_sh_q[DATA_W-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                : {1'b0, tx_sh_q[DATA_W-1:1]};

  assign full     = (level_q == LVL_FULL);
  assign pop      = (level_q != '0) && bus.rx_ready;
  assign push_ok  = last && (!full || pop);
  assign overrun  = last && full && !pop;
  assign underrun = first_bit && !primed_q;

  always_comb begin
    cnt_d      = cnt_q;
    st_d       = st_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    primed_d   = primed_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;

    if (sel) begin
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      rx_sh_d = rx_shifted;
    end else begin
      cnt_d = '0;
      if (abort) begin
        rx_sh_d = '0;
      end
    end
    st_d = (cnt_d != '0) ? ST_SHIFT : ST_IDLE;

    if (load) begin
      if (tx_avail) begin
        tx_sh_d  = tx_next;
        primed_d = 1'b1;
      end else begin
        tx_sh_d  = '0;
        primed_d = 1'b0;
      end
    end else if (sel) begin
      tx_sh_d = tx_shifted;
    end else if (abort) begin
      tx_sh_d  = '0;
      primed_d = 1'b0;
    end

    // A load with the holding register empty consumes tx_data directly (bypass).
    if (load && hold_vld_q) begin
      hold_vld_d = 1'b0;
    end else if (tx_acc && !load) begin
      hold_vld_d = 1'b1;
      hold_d     = bus.tx_data;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_shifted;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sclk or posedge i_reset) begin
    if (i_reset) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      primed_q   <= primed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef SPI_SLV_ERR_EN
  logic [1:0] err_q, err_d;

  // Same-edge set beats clear so no event is lost.
  always_comb begin
    err_d = (bus.err_clr ? 2'b00 : err_q) | {underrun, overrun};
  end

  always_ff @(posedge sclk or posedge i_reset) begin
    if (i_reset) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_flags;
  assign unused_flags = overrun ^ underrun;
`endif

  assign bus.miso     = MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
  assign bus.tx_ready = ~hold_vld_q;
  assign bus.dout     = mem_q[rd_ptr_q];
  assign bus.rx_valid = (level_q != '0);
  assign bus.rx_level = level_q;
  assign bus.busy     = (st_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo: MSB-first and LSB-first instances on a shared sclk/reset.
module tb_spi_slave_fifo;
  logic sclk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 sclk = ~sclk;

  spi_slave_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4)) m_if ();
  spi_slave_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4)) l_if ();

  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .sclk(sclk), .i_reset(rst), .bus(m_if)
  );
  spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .sclk(sclk), .i_reset(rst), .bus(l_if)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic xfer_m(input logic [7:0] mo, output logic [7:0] mi);
    m_if.cs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_if.mosi = mo[i];
      mi[i] = m_if.miso;
      tick();
    end
  endtask

  task automatic xfer_l(input logic [7:0] mo, output logic [7:0] mi);
    l_if.cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l_if.mosi = mo[i];
      mi[i] = l_if.miso;
      tick();
    end
  endtask

  task automatic pop_m(input string name, input logic [7:0] exp);
    chk(name, m_if.dout, exp);
    m_if.rx_ready = 1'b1;
    tick();
    m_if.rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] ab;
    logic [7:0] tw [3];
    logic [7:0] rw [3];
    logic [7:0] bw [3];
    logic [7:0] w6;

    m_if.cs = 1'b1; m_if.mosi = 1'b0; m_if.tx_data = '0; m_if.tx_valid = 1'b0; m_if.rx_ready = 1'b0;
    l_if.cs = 1'b1; l_if.mosi = 1'b0; l_if.tx_data = '0; l_if.tx_valid = 1'b0; l_if.rx_ready = 1'b0;
`ifdef SPI_SLV_ERR_EN
    m_if.err_clr = 1'b0;
    l_if.err_clr = 1'b0;
`endif
    rst = 1'b1;
    tick();
    tick();
    chk("rst_miso", m_if.miso, 0);
    chk("rst_tx_ready", m_if.tx_ready, 1);
    chk("rst_dout", m_if.dout, 0);
    chk("rst_rx_valid", m_if.rx_valid, 0);
    chk("rst_rx_level", m_if.rx_level, 0);
    chk("rst_busy", m_if.busy, 0);
`ifdef SPI_SLV_ERR_EN
    chk("rst_err", m_if.err, 0);
`endif
    rst = 1'b0;
    tick();

    // Single words, MSB first, bypass preload in IDLE.
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    for (int v = 0; v < 4; v++) begin
      m_if.tx_data  = vecs[v].tx;
      m_if.tx_valid = 1'b1;
      tick();
      m_if.tx_valid = 1'b0;
      chk("tbl_tx_ready", m_if.tx_ready, 1);
      xfer_m(vecs[v].mosi, mi);
      m_if.cs = 1'b1;
      chk("tbl_miso", mi, vecs[v].exp_miso);
      chk("tbl_rx_valid", m_if.rx_valid, 1);
      chk("tbl_rx_level", m_if.rx_level, 1);
      chk("tbl_busy", m_if.busy, 0);
      pop_m("tbl_dout", vecs[v].exp_dout);
      chk("tbl_rx_empty", m_if.rx_valid, 0);
    end

    // Burst of three words with cs held low, next TX word fed into the holding register.
    tw[0] = 8'h81; tw[1] = 8'h42; tw[2] = 8'h24;
    rw[0] = 8'h11; rw[1] = 8'h22; rw[2] = 8'h33;
    m_if.tx_data  = tw[0];
    m_if.tx_valid = 1'b1;
    tick();
    m_if.tx_valid = 1'b0;
    m_if.cs = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 7; i >= 0; i--) begin
        if (i == 7 && w < 2) begin
          m_if.tx_data  = tw[w+1];
          m_if.tx_valid = 1'b1;
        end
        m_if.mosi = rw[w][i];
        bw[w][i] = m_if.miso;
        tick();
        m_if.tx_valid = 1'b0;
        if (w == 0 && i == 7) chk("burst_hold_full", m_if.tx_ready, 0);
      end
    end
    m_if.cs = 1'b1;
    chk("burst_miso0", bw[0], 8'h81);
    chk("burst_miso1", bw[1], 8'h42);
    chk("burst_miso2", bw[2], 8'h24);
    chk("burst_level", m_if.rx_level, 3);
    chk("burst_tx_ready", m_if.tx_ready, 1);
    pop_m("burst_dout0", 8'h11);
    pop_m("burst_dout1", 8'h22);
    pop_m("burst_dout2", 8'h33);

    // Underrun: nothing to send.
    xfer_m(8'h5A, mi);
    m_if.cs = 1'b1;
    chk("under_miso", mi, 8'h00);
`ifdef SPI_SLV_ERR_EN
    chk("under_err", m_if.err, 2'b10);
    m_if.err_clr = 1'b1;
    tick();
    m_if.err_clr = 1'b0;
    chk("under_err_clr", m_if.err, 2'b00);
`endif
    pop_m("under_dout", 8'h5A);

    // Overrun: five words into a four-entry FIFO, then push+pop at full.
    for (int w = 1; w <= 5; w++) begin
      xfer_m(8'(w), mi);
    end
    m_if.cs = 1'b1;
    chk("ovr_level", m_if.rx_level, 4);
    chk("ovr_head", m_if.dout, 8'h01);
`ifdef SPI_SLV_ERR_EN
    chk("ovr_err", m_if.err, 2'b11);
    m_if.err_clr = 1'b1;
    tick();
    m_if.err_clr = 1'b0;
`endif
    w6 = 8'h66;
    m_if.cs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_if.mosi = w6[i];
      if (i == 0) m_if.rx_ready = 1'b1;
      tick();
      m_if.rx_ready = 1'b0;
    end
    m_if.cs = 1'b1;
    chk("simul_level", m_if.rx_level, 4);
`ifdef SPI_SLV_ERR_EN
    chk("simul_no_ovr", m_if.err[0], 0);
`endif
    pop_m("simul_dout0", 8'h02);
    pop_m("simul_dout1", 8'h03);
    pop_m("simul_dout2", 8'h04);
    pop_m("simul_dout3", 8'h66);
    chk("simul_empty", m_if.rx_level, 0);

    // Abort after 3 bits: holding word reloads and goes out in the next frame.
    m_if.tx_data  = 8'hC3;
    m_if.tx_valid = 1'b1;
    tick();
    m_if.tx_data = 8'h96;
    tick();
    m_if.tx_valid = 1'b0;
    chk("abort_hold_full", m_if.tx_ready, 0);
    ab = '0;
    m_if.cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_if.mosi = 1'b1;
      ab[i] = m_if.miso;
      tick();
    end
    chk("abort_bits", ab, 8'h03);
    chk("abort_busy_mid", m_if.busy, 1);
    m_if.cs = 1'b1;
    tick();
    chk("abort_busy", m_if.busy, 0);
    chk("abort_level", m_if.rx_level, 0);
    chk("abort_hold_kept", m_if.tx_ready, 0);
    chk("abort_miso", m_if.miso, 0);
    tick();
    chk("abort_reload_rdy", m_if.tx_ready, 1);
    xfer_m(8'h00, mi);
    m_if.cs = 1'b1;
    chk("abort_retx", mi, 8'h96);
    chk("abort_level2", m_if.rx_level, 1);
    pop_m("abort_dout", 8'h00);

    // LSB-first instance.
    l_if.tx_data  = 8'h80;
    l_if.tx_valid = 1'b1;
    tick();
    l_if.tx_valid = 1'b0;
    xfer_l(8'h01, mi);
    chk("lsb_miso0", mi, 8'h80);
    l_if.tx_data  = 8'h35;
    l_if.tx_valid = 1'b1;
    l_if.cs = 1'b1;
    tick();
    l_if.tx_valid = 1'b0;
    xfer_l(8'hB2, mi);
    l_if.cs = 1'b1;
    chk("lsb_miso1", mi, 8'h35);
    chk("lsb_level", l_if.rx_level, 2);
    chk("lsb_dout0", l_if.dout, 8'h01);
    l_if.rx_ready = 1'b1;
    tick();
    l_if.rx_ready = 1'b0;
    chk("lsb_dout1", l_if.dout, 8'hB2);

    // Asynchronous reset in the middle of a word.
    xfer_m(8'h5A, mi);
    m_if.cs = 1'b1;
    m_if.tx_data  = 8'hFF;
    m_if.tx_valid = 1'b1;
    tick();
    tick();
    m_if.tx_valid = 1'b0;
    m_if.cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_if.mosi = 1'b1;
      tick();
    end
    chk("pre_rst_busy", m_if.busy, 1);
    chk("pre_rst_miso", m_if.miso, 1);
    chk("pre_rst_rx_valid", m_if.rx_valid, 1);
    chk("pre_rst_tx_ready", m_if.tx_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_miso", m_if.miso, 0);
    chk("arst_tx_ready", m_if.tx_ready, 1);
    chk("arst_dout", m_if.dout, 0);
    chk("arst_rx_valid", m_if.rx_valid, 0);
    chk("arst_rx_level", m_if.rx_level, 0);
    chk("arst_busy", m_if.busy, 0);
`ifdef SPI_SLV_ERR_EN
    chk("arst_err", m_if.err, 0);
`endif
    m_if.cs = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", m_if.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
